// File: rtl/vdp_pkg.sv
// Shared types and elaboration-time helpers for the vector dot-product engine.
// Latency: none (types and constant functions only). Backpressure: not applicable.
package vdp_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  function automatic int beats(input int vector_size, input int lanes);
    return (vector_size + lanes - 1) / lanes;
  endfunction

  // Wide enough that summing every product of the vector can never wrap.
  function automatic int acc_width(input int data_width, input int vector_size);
    return 2 * data_width + $clog2(vector_size) + 1;
  endfunction

endpackage

// File: rtl/vdp_lane_tree.sv
// One multiplier per lane and the sum of their products for a single beat.
// Latency: combinational. Backpressure: none, the result follows the operand slice.
module vdp_lane_tree #(
  parameter int DATA_WIDTH = 31,
  parameter int LANES      = 1,
  parameter int SUM_W      = 65
) (
  input  logic [LANES*DATA_WIDTH-1:0] a_i,
  input  logic [LANES*DATA_WIDTH-1:0] b_i,
  input  logic                        signed_mode_i,
  output logic signed [SUM_W-1:0]     sum_o
);

  localparam int PROD_W = 2 * DATA_WIDTH + 2;

  logic signed [PROD_W-1:0] prod [LANES];

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    logic signed [DATA_WIDTH:0] ax;
    logic signed [DATA_WIDTH:0] bx;
    // One extra bit lets the same signed multiplier serve both modes.
    assign ax = {signed_mode_i & a_i[l*DATA_WIDTH+DATA_WIDTH-1], a_i[l*DATA_WIDTH +: DATA_WIDTH]};
    assign bx = {signed_mode_i & b_i[l*DATA_WIDTH+DATA_WIDTH-1], b_i[l*DATA_WIDTH +: DATA_WIDTH]};
    assign prod[l] = ax * bx;
  end

  // Every product fits in SUM_W, so narrowing here never loses value.
  always_comb begin
    sum_o = '0;
    for (int l = 0; l < LANES; l++) begin
      sum_o = sum_o + SUM_W'(prod[l]);
    end
  end

endmodule

// File: rtl/vector_dot_product_pmc.sv
// Multi-cycle dot product, LANES products per beat, with saturating/wrapping result fit.
// Latency: valid BEATS+1 edges after start is sampled. Backpressure: start ignored while busy.
module vector_dot_product_pmc
  import vdp_pkg::*;
#(
  parameter int VECTOR_SIZE  = 4,
  parameter int DATA_WIDTH   = 31,
  parameter int RESULT_WIDTH = 31,
  parameter int LANES        = 1,
  parameter int SATURATE     = 1
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              start,
  input  logic                              signed_mode,
  input  logic [VECTOR_SIZE*DATA_WIDTH-1:0] vec1,
  input  logic [VECTOR_SIZE*DATA_WIDTH-1:0] vec2,
  output logic [RESULT_WIDTH-1:0]           result,
  output logic                              valid,
  output logic                              busy,
  output logic                              overflow
);

  localparam int BEATS   = beats(VECTOR_SIZE, LANES);
  localparam int ACC_W   = acc_width(DATA_WIDTH, VECTOR_SIZE);
  localparam int SLICE_W = LANES * DATA_WIDTH;
  localparam int OP_W    = BEATS * SLICE_W;
  localparam int CNT_W   = $clog2(BEATS + 1);
  localparam int CMP_W   = (ACC_W > RESULT_WIDTH + 1) ? ACC_W : RESULT_WIDTH + 1;

  localparam logic signed [CMP_W-1:0] ONE  = 1;
  localparam logic signed [CMP_W-1:0] ZERO = 0;
  localparam logic signed [CMP_W-1:0] SMAX = (ONE <<< (RESULT_WIDTH - 1)) - ONE;
  localparam logic signed [CMP_W-1:0] SMIN = -(ONE <<< (RESULT_WIDTH - 1));
  localparam logic signed [CMP_W-1:0] UMAX = (ONE <<< RESULT_WIDTH) - ONE;

  state_e state_q, state_d;

  logic [OP_W-1:0]          opa_q, opa_d;
  logic [OP_W-1:0]          opb_q, opb_d;
  logic                     mode_q, mode_d;
  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic [RESULT_WIDTH-1:0]  result_q, result_d;
  logic                     ovf_q, ovf_d;

  logic                     accept;
  logic                     acc_done;
  logic signed [ACC_W-1:0]  part_sum;
  logic signed [CMP_W-1:0]  acc_x, hi, lo, clamped;
  logic [RESULT_WIDTH-1:0]  fit_res;
  logic                     fit_ovf;

  assign accept   = start && (state_q != RUN);
  assign acc_done = (cnt_q == CNT_W'(BEATS));

  // ---------------- FSM ----------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start)    state_d = RUN;
      RUN:     if (acc_done) state_d = DONE;
      DONE:    if (start)    state_d = RUN;
      default:               state_d = IDLE;
    endcase
  end

  always_comb begin
    busy  = (state_q == RUN);
    valid = (state_q == DONE);
  end

  // ---------------- datapath ----------------
  // The operand latches shift down one beat at a time, so the tree always reads the low slice.
  vdp_lane_tree #(
    .DATA_WIDTH (DATA_WIDTH),
    .LANES      (LANES),
    .SUM_W      (ACC_W)
  ) u_tree (
    .a_i           (opa_q[SLICE_W-1:0]),
    .b_i           (opb_q[SLICE_W-1:0]),
    .signed_mode_i (mode_q),
    .sum_o         (part_sum)
  );

  // Range check runs in a width that holds both the accumulator and the widest limit.
  always_comb begin
    acc_x   = CMP_W'(acc_q);
    hi      = mode_q ? SMAX : UMAX;
    lo      = mode_q ? SMIN : ZERO;
    fit_ovf = (acc_x > hi) || (acc_x < lo);
    clamped = acc_x;
    if (SATURATE != 0) begin
      if (acc_x > hi) begin
        clamped = hi;
      end else if (acc_x < lo) begin
        clamped = lo;
      end
    end
    fit_res = clamped[RESULT_WIDTH-1:0];
  end

  always_comb begin
    opa_d    = opa_q;
    opb_d    = opb_q;
    mode_d   = mode_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    ovf_d    = ovf_q;
    if (accept) begin
      // Zero padding beyond VECTOR_SIZE makes the surplus lanes of the last beat add nothing.
      opa_d  = OP_W'(vec1);
      opb_d  = OP_W'(vec2);
      mode_d = signed_mode;
      acc_d  = '0;
      cnt_d  = '0;
      ovf_d  = 1'b0;
    end else if (state_q == RUN) begin
      if (!acc_done) begin
        acc_d = acc_q + part_sum;
        cnt_d = cnt_q + CNT_W'(1);
        opa_d = opa_q >> SLICE_W;
        opb_d = opb_q >> SLICE_W;
      end else begin
        result_d = fit_res;
        ovf_d    = fit_ovf;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      opa_q    <= '0;
      opb_q    <= '0;
      mode_q   <= 1'b0;
      acc_q    <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      ovf_q    <= 1'b0;
    end else begin
      opa_q    <= opa_d;
      opb_q    <= opb_d;
      mode_q   <= mode_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      ovf_q    <= ovf_d;
    end
  end

  assign result   = result_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_vector_dot_product_pmc.sv
// Bench for vector_dot_product_pmc: five configurations checked against tables,
// an arithmetic reference model on random vectors, and hand-written corner sequences.
module tb_vector_dot_product_pmc;

  localparam int VS  = 4;
  localparam int DWA = 31;
  localparam int DWB = 8;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic              start_a, sm_a;
  logic [VS*DWA-1:0] v1_a, v2_a;
  logic [DWA-1:0]    res_a  [3];
  logic              val_a  [3];
  logic              busy_a [3];
  logic              ovf_a  [3];

  logic              start_b, sm_b;
  logic [VS*DWB-1:0] v1_b, v2_b;
  logic [DWB-1:0]    res_b  [2];
  logic              val_b  [2];
  logic              busy_b [2];
  logic              ovf_b  [2];

  int total = 0;
  int bad   = 0;
  int lat_a [3];
  int lat_b [2];
  int exp_lat_a [3] = '{5, 3, 3};

  vector_dot_product_pmc #(.VECTOR_SIZE(VS), .DATA_WIDTH(DWA), .RESULT_WIDTH(DWA), .LANES(1), .SATURATE(1)) ua0 (
    .clk(clk), .reset(reset), .start(start_a), .signed_mode(sm_a), .vec1(v1_a), .vec2(v2_a),
    .result(res_a[0]), .valid(val_a[0]), .busy(busy_a[0]), .overflow(ovf_a[0]));
  vector_dot_product_pmc #(.VECTOR_SIZE(VS), .DATA_WIDTH(DWA), .RESULT_WIDTH(DWA), .LANES(2), .SATURATE(1)) ua1 (
    .clk(clk), .reset(reset), .start(start_a), .signed_mode(sm_a), .vec1(v1_a), .vec2(v2_a),
    .result(res_a[1]), .valid(val_a[1]), .busy(busy_a[1]), .overflow(ovf_a[1]));
  vector_dot_product_pmc #(.VECTOR_SIZE(VS), .DATA_WIDTH(DWA), .RESULT_WIDTH(DWA), .LANES(3), .SATURATE(1)) ua2 (
    .clk(clk), .reset(reset), .start(start_a), .signed_mode(sm_a), .vec1(v1_a), .vec2(v2_a),
    .result(res_a[2]), .valid(val_a[2]), .busy(busy_a[2]), .overflow(ovf_a[2]));
  vector_dot_product_pmc #(.VECTOR_SIZE(VS), .DATA_WIDTH(DWB), .RESULT_WIDTH(DWB), .LANES(1), .SATURATE(1)) ub0 (
    .clk(clk), .reset(reset), .start(start_b), .signed_mode(sm_b), .vec1(v1_b), .vec2(v2_b),
    .result(res_b[0]), .valid(val_b[0]), .busy(busy_b[0]), .overflow(ovf_b[0]));
  vector_dot_product_pmc #(.VECTOR_SIZE(VS), .DATA_WIDTH(DWB), .RESULT_WIDTH(DWB), .LANES(1), .SATURATE(0)) ub1 (
    .clk(clk), .reset(reset), .start(start_b), .signed_mode(sm_b), .vec1(v1_b), .vec2(v2_b),
    .result(res_b[1]), .valid(val_b[1]), .busy(busy_b[1]), .overflow(ovf_b[1]));

  typedef struct packed {
    logic              sm;
    logic [VS*DWA-1:0] a;
    logic [VS*DWA-1:0] b;
    logic [DWA-1:0]    res;
    logic              ovf;
  } rec_a_t;

  typedef struct packed {
    logic              sm;
    logic [VS*DWB-1:0] a;
    logic [VS*DWB-1:0] b;
    logic [DWB-1:0]    rsat;
    logic [DWB-1:0]    rwrap;
    logic              ovf;
  } rec_b_t;

  rec_a_t ta [10];
  rec_b_t tb [10];

  function automatic logic [VS*DWA-1:0] pa(input int e0, input int e1, input int e2, input int e3);
    return {DWA'(e3), DWA'(e2), DWA'(e1), DWA'(e0)};
  endfunction

  function automatic logic [VS*DWB-1:0] pb(input int e0, input int e1, input int e2, input int e3);
    return {DWB'(e3), DWB'(e2), DWB'(e1), DWB'(e0)};
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // Reference: exact integer dot product, then clamp or truncate to rw bits.
  function automatic void ref_dp(input int dw, input int rw, input bit sat, input logic sm,
                                 input logic [127:0] a, input logic [127:0] b,
                                 output logic [63:0] res, output logic ovf);
    logic signed [127:0] acc, ea, eb, hi, lo;
    acc = 0;
    for (int i = 0; i < VS; i++) begin
      ea = 0;
      eb = 0;
      for (int k = 0; k < dw; k++) begin
        ea[k] = a[i*dw+k];
        eb[k] = b[i*dw+k];
      end
      if (sm && ea[dw-1]) ea = ea - (128'sd1 <<< dw);
      if (sm && eb[dw-1]) eb = eb - (128'sd1 <<< dw);
      acc = acc + ea * eb;
    end
    if (sm) begin
      hi = (128'sd1 <<< (rw - 1)) - 128'sd1;
      lo = -(128'sd1 <<< (rw - 1));
    end else begin
      hi = (128'sd1 <<< rw) - 128'sd1;
      lo = 0;
    end
    ovf = (acc > hi) || (acc < lo);
    if (sat && acc > hi) acc = hi;
    else if (sat && acc < lo) acc = lo;
    res = 64'(acc) & ((64'd1 << rw) - 64'd1);
  endfunction

  task automatic run_a(input logic sm, input logic [VS*DWA-1:0] a, input logic [VS*DWA-1:0] b);
    @(negedge clk);
    sm_a = sm; v1_a = a; v2_a = b; start_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0;
    for (int d = 0; d < 3; d++) begin
      lat_a[d] = 0;
      chk($sformatf("A busy after accept d%0d", d), busy_a[d], 1);
      chk($sformatf("A valid low after accept d%0d", d), val_a[d], 0);
    end
    for (int e = 1; e <= 8; e++) begin
      @(posedge clk); #1;
      for (int d = 0; d < 3; d++) if (val_a[d] && lat_a[d] == 0) lat_a[d] = e;
    end
  endtask

  task automatic run_b(input logic sm, input logic [VS*DWB-1:0] a, input logic [VS*DWB-1:0] b);
    @(negedge clk);
    sm_b = sm; v1_b = a; v2_b = b; start_b = 1'b1;
    @(posedge clk); #1;
    start_b = 1'b0;
    for (int d = 0; d < 2; d++) lat_b[d] = 0;
    for (int e = 1; e <= 8; e++) begin
      @(posedge clk); #1;
      for (int d = 0; d < 2; d++) if (val_b[d] && lat_b[d] == 0) lat_b[d] = e;
    end
  endtask

  task automatic check_a(input string tag, input logic [DWA-1:0] er, input logic eo);
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("%s latency d%0d", tag, d), lat_a[d], exp_lat_a[d]);
      chk($sformatf("%s result d%0d", tag, d), res_a[d], er);
      chk($sformatf("%s overflow d%0d", tag, d), ovf_a[d], eo);
    end
  endtask

  task automatic check_b(input string tag, input logic [DWB-1:0] es, input logic [DWB-1:0] ew, input logic eo);
    chk($sformatf("%s latency sat", tag), lat_b[0], 5);
    chk($sformatf("%s latency wrap", tag), lat_b[1], 5);
    chk($sformatf("%s result sat", tag), res_b[0], es);
    chk($sformatf("%s result wrap", tag), res_b[1], ew);
    chk($sformatf("%s overflow sat", tag), ovf_b[0], eo);
    chk($sformatf("%s overflow wrap", tag), ovf_b[1], eo);
  endtask

  initial begin
    logic [63:0] mres, mres2;
    logic        movf;
    logic [VS*DWA-1:0] ra, rb;
    logic [VS*DWB-1:0] qa, qb;
    logic        rsm;
    int rises [3];
    int late_busy [3];
    logic pv [3];
    logic seen [3];

    ta[0] = {1'b0, pa(1, 2, 3, 4), pa(5, 6, 7, 8), 31'd70, 1'b0};
    ta[1] = {1'b1, pa(-1, 2, -3, 4), pa(5, 6, 7, 8), 31'd18, 1'b0};
    ta[2] = {1'b1, pa(-1, -1, -1, -1), pa(1, 1, 1, 1), 31'h7FFFFFFC, 1'b0};
    ta[3] = {1'b0, pa(2147483647, 2147483647, 2147483647, 2147483647),
                   pa(2147483647, 2147483647, 2147483647, 2147483647), 31'h7FFFFFFF, 1'b1};
    ta[4] = {1'b1, pa(1073741823, 0, 0, 0), pa(1, 0, 0, 0), 31'h3FFFFFFF, 1'b0};
    ta[5] = {1'b1, pa(32768, 0, 0, 0), pa(32768, 0, 0, 0), 31'h3FFFFFFF, 1'b1};
    ta[6] = {1'b1, pa(-1073741824, 0, 0, 0), pa(1, 0, 0, 0), 31'h40000000, 1'b0};
    ta[7] = {1'b1, pa(-1073741824, -1, 0, 0), pa(1, 1, 0, 0), 31'h40000000, 1'b1};
    ta[8] = {1'b0, pa(2147483647, 1, 0, 0), pa(1, 1, 0, 0), 31'h7FFFFFFF, 1'b1};
    ta[9] = {1'b1, pa(-1073741824, -1073741824, -1073741824, -1073741824),
                   pa(1073741823, 1073741823, 1073741823, 1073741823), 31'h40000000, 1'b1};

    tb[0] = {1'b0, pb(255, 255, 255, 255), pb(255, 255, 255, 255), 8'hFF, 8'h04, 1'b1};
    tb[1] = {1'b1, pb(-128, -128, -128, -128), pb(-128, -128, -128, -128), 8'h7F, 8'h00, 1'b1};
    tb[2] = {1'b1, pb(-128, -128, -128, -128), pb(127, 127, 127, 127), 8'h80, 8'h00, 1'b1};
    tb[3] = {1'b1, pb(10, 0, 0, 0), pb(12, 0, 0, 0), 8'h78, 8'h78, 1'b0};
    tb[4] = {1'b1, pb(64, 0, 0, 0), pb(2, 0, 0, 0), 8'h7F, 8'h80, 1'b1};
    tb[5] = {1'b1, pb(-128, -1, 0, 0), pb(1, 1, 0, 0), 8'h80, 8'h7F, 1'b1};
    tb[6] = {1'b0, pb(255, 1, 0, 0), pb(1, 1, 0, 0), 8'hFF, 8'h00, 1'b1};
    tb[7] = {1'b0, pb(255, 0, 0, 0), pb(1, 0, 0, 0), 8'hFF, 8'hFF, 1'b0};
    tb[8] = {1'b1, pb(-128, 0, 0, 0), pb(1, 0, 0, 0), 8'h80, 8'h80, 1'b0};
    tb[9] = {1'b1, pb(-3, 5, -7, 2), pb(9, -4, 6, -8), 8'h97, 8'h97, 1'b0};

    start_a = 1'b0; sm_a = 1'b0; v1_a = '0; v2_a = '0;
    start_b = 1'b0; sm_b = 1'b0; v1_b = '0; v2_b = '0;
    reset = 1'b1;
    #2 reset = 1'b0;
    #20;
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("reset result A%0d", d), res_a[d], 0);
      chk($sformatf("reset valid A%0d", d), val_a[d], 0);
      chk($sformatf("reset busy A%0d", d), busy_a[d], 0);
      chk($sformatf("reset overflow A%0d", d), ovf_a[d], 0);
    end
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("reset result B%0d", d), res_b[d], 0);
      chk($sformatf("reset valid B%0d", d), val_b[d], 0);
    end
    @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i < 10; i++) begin
      run_a(ta[i].sm, ta[i].a, ta[i].b);
      check_a($sformatf("tabA%0d", i), ta[i].res, ta[i].ovf);
    end
    for (int i = 0; i < 10; i++) begin
      run_b(tb[i].sm, tb[i].a, tb[i].b);
      check_b($sformatf("tabB%0d", i), tb[i].rsat, tb[i].rwrap, tb[i].ovf);
    end

    for (int n = 0; n < 25; n++) begin
      rsm = 1'($urandom_range(0, 1));
      for (int i = 0; i < VS; i++) begin
        ra[i*DWA +: DWA] = DWA'($urandom >> $urandom_range(0, 31));
        rb[i*DWA +: DWA] = DWA'($urandom >> $urandom_range(0, 31));
        qa[i*DWB +: DWB] = DWB'($urandom);
        qb[i*DWB +: DWB] = DWB'($urandom >> $urandom_range(0, 7));
      end
      run_a(rsm, ra, rb);
      ref_dp(DWA, DWA, 1'b1, rsm, 128'(ra), 128'(rb), mres, movf);
      check_a($sformatf("rndA%0d", n), DWA'(mres), movf);
      run_b(rsm, qa, qb);
      ref_dp(DWB, DWB, 1'b1, rsm, 128'(qa), 128'(qb), mres, movf);
      ref_dp(DWB, DWB, 1'b0, rsm, 128'(qa), 128'(qb), mres2, movf);
      check_b($sformatf("rndB%0d", n), DWB'(mres), DWB'(mres2), movf);
    end

    // Operand change plus a start pulse while running must not disturb the result.
    @(negedge clk);
    sm_a = 1'b0; v1_a = pa(1, 2, 3, 4); v2_a = pa(5, 6, 7, 8); start_a = 1'b1;
    @(posedge clk); #1;
    for (int d = 0; d < 3; d++) begin
      rises[d] = 0; late_busy[d] = 0; pv[d] = 1'b0; seen[d] = 1'b0;
    end
    for (int e = 1; e <= 14; e++) begin
      @(negedge clk);
      start_a = (e == 2);
      if (e == 2) v1_a = '0;
      @(posedge clk); #1;
      for (int d = 0; d < 3; d++) begin
        if (val_a[d] && !pv[d]) rises[d]++;
        if (seen[d] && busy_a[d]) late_busy[d]++;
        if (val_a[d]) seen[d] = 1'b1;
        pv[d] = val_a[d];
      end
    end
    start_a = 1'b0;
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("midrun result d%0d", d), res_a[d], 70);
      chk($sformatf("midrun valid rises d%0d", d), rises[d], 1);
      chk($sformatf("midrun no rerun d%0d", d), late_busy[d], 0);
    end

    // Asynchronous reset in the middle of a run.
    @(negedge clk);
    sm_a = 1'b0; v1_a = pa(1, 2, 3, 4); v2_a = pa(5, 6, 7, 8); start_a = 1'b1;
    sm_b = 1'b0; v1_b = pb(1, 2, 3, 4); v2_b = pb(5, 6, 7, 8); start_b = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start_a = 1'b0; start_b = 1'b0;
    @(posedge clk);
    @(posedge clk); #1;
    chk("busy before reset A0", busy_a[0], 1);
    chk("busy before reset B0", busy_b[0], 1);
    #2 reset = 1'b0;
    #1;
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("abort result A%0d", d), res_a[d], 0);
      chk($sformatf("abort valid A%0d", d), val_a[d], 0);
      chk($sformatf("abort busy A%0d", d), busy_a[d], 0);
      chk($sformatf("abort overflow A%0d", d), ovf_a[d], 0);
    end
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("abort result B%0d", d), res_b[d], 0);
      chk($sformatf("abort busy B%0d", d), busy_b[d], 0);
    end
    @(negedge clk);
    reset = 1'b1;
    run_a(1'b0, pa(1, 1, 1, 1), pa(2, 2, 2, 2));
    check_a("after reset", 31'd8, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
